async_pipe_injector_arb: RTL

//   Synchronous front-end that shares the input of the 16-bit asynchronous

---
 rtl/async_pipe_injector_arb_if.sv | 15 +
 rtl/async_pipe_injector_arb.sv | 100 ++++++++++
 2 files changed

// File: rtl/async_pipe_injector_arb_if.sv
// async_pipe_injector_arb_if: requester, token and ack signals of the async pipe injector
interface async_pipe_injector_arb_if #(parameter int CNT_W = 16);
  logic req0, req1, gnt0, gnt1, ack_in, busy, err;
  logic [13:0] data0, data1;
  logic [15:0] data_out;
  logic [CNT_W-1:0] tok_cnt;
  modport master (
    output req0, data0, req1, data1, ack_in,
    input gnt0, gnt1, data_out, busy, err, tok_cnt
  );
  modport slave (
    input req0, data0, req1, data1, ack_in,
    output gnt0, gnt1, data_out, busy, err, tok_cnt
  );
endinterface

// File: rtl/async_pipe_injector_arb.sv
// async_pipe_injector_arb: round-robin injector of tagged tokens into a 4-phase RTZ async pipeline
module async_pipe_injector_arb #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input logic clk,
  input logic rst,
  async_pipe_injector_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, RTZ, ERR} state_t;
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d, warm_q, warm_d;
  logic [15:0] data_out_q, data_out_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] tok_q, tok_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, last1_q, last1_d, busy_q, busy_d, err_q, err_d;
  logic ack_s, ready, pick1, expired;
  assign ack_s = sync_q[SYNC_STAGES-1];
  // ack_s is only trusted once the synchronizer has refilled after reset
  assign ready = warm_q[SYNC_STAGES-1];
  assign pick1 = bus.req1 & (~bus.req0 | ~last1_q);
  assign expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_MAX);
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.ack_in};
    warm_d = {warm_q[SYNC_STAGES-2:0], 1'b1};
    state_d = state_q;
    data_out_d = data_out_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    last1_d = last1_q;
    wd_d = wd_q + 1'b1;
    tok_d = tok_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (ready && !ack_s && (bus.req0 || bus.req1)) begin
        state_d = SEND;
        data_out_d = pick1 ? {2'b10, bus.data1} : {2'b01, bus.data0};
        gnt0_d = ~pick1;
        gnt1_d = pick1;
        last1_d = pick1;
        wd_d = '0;
      end
      SEND: if (ack_s) begin
        state_d = RTZ;
        data_out_d = '0;
        wd_d = '0;
      end else if (expired) begin
        state_d = ERR;
      end
      RTZ: if (!ack_s) begin
        state_d = IDLE;
        tok_d = tok_q + 1'b1;
      end else if (expired) begin
        state_d = ERR;
      end
      default: state_d = ERR;
    endcase
    if (state_d == ERR) begin
      data_out_d = '0;
      err_d = 1'b1;
    end
    busy_d = (state_d == SEND) || (state_d == RTZ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      warm_q <= '0;
      data_out_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      last1_q <= 1'b1;
      wd_q <= '0;
      tok_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      warm_q <= warm_d;
      data_out_q <= data_out_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      last1_q <= last1_d;
      wd_q <= wd_d;
      tok_q <= tok_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign bus.data_out = data_out_q;
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.busy = busy_q;
  assign bus.err = err_q;
  assign bus.tok_cnt = tok_q;
endmodule
